// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and an optional skid entry.
// SKID=1 registers in_ready; SKID=0 gives a single entry with a combinational in_ready.
module ex_mem_skid_stage #(
  parameter int word_width = 32,
  parameter int CTRL_W     = 4,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [word_width-1:0] in_alu,
  input  logic [word_width-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  input  logic [word_width-1:0] in_pcplus4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [word_width-1:0] out_alu,
  output logic [word_width-1:0] out_wdata,
  output logic [4:0]            out_rd,
  output logic [word_width-1:0] out_pcplus4,
  output logic [1:0]            occupancy
);

  logic                  r_main_valid;
  logic [CTRL_W-1:0]     r_main_ctrl;
  logic [word_width-1:0] r_main_alu;
  logic [word_width-1:0] r_main_wdata;
  logic [4:0]            r_main_rd;
  logic [word_width-1:0] r_main_pcplus4;

  logic w_skid_valid;
  logic w_accept;
  logic w_pop;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = r_main_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic                  r_skid_valid;
      logic [CTRL_W-1:0]     r_skid_ctrl;
      logic [word_width-1:0] r_skid_alu;
      logic [word_width-1:0] r_skid_wdata;
      logic [4:0]            r_skid_rd;
      logic [word_width-1:0] r_skid_pcplus4;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_main_valid   <= 1'b0;
          r_main_ctrl    <= '0;
          r_main_alu     <= '0;
          r_main_wdata   <= '0;
          r_main_rd      <= '0;
          r_main_pcplus4 <= '0;
          r_skid_valid   <= 1'b0;
          r_skid_ctrl    <= '0;
          r_skid_alu     <= '0;
          r_skid_wdata   <= '0;
          r_skid_rd      <= '0;
          r_skid_pcplus4 <= '0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (w_pop && r_skid_valid) begin
          // in_ready is low here, so no accept can coincide with the refill
          r_main_ctrl    <= r_skid_ctrl;
          r_main_alu     <= r_skid_alu;
          r_main_wdata   <= r_skid_wdata;
          r_main_rd      <= r_skid_rd;
          r_main_pcplus4 <= r_skid_pcplus4;
          r_skid_valid   <= 1'b0;
        end else if (w_accept && (!r_main_valid || w_pop)) begin
          r_main_valid   <= 1'b1;
          r_main_ctrl    <= in_ctrl;
          r_main_alu     <= in_alu;
          r_main_wdata   <= in_wdata;
          r_main_rd      <= in_rd;
          r_main_pcplus4 <= in_pcplus4;
        end else if (w_accept) begin
          r_skid_valid   <= 1'b1;
          r_skid_ctrl    <= in_ctrl;
          r_skid_alu     <= in_alu;
          r_skid_wdata   <= in_wdata;
          r_skid_rd      <= in_rd;
          r_skid_pcplus4 <= in_pcplus4;
        end else if (w_pop) begin
          r_main_valid <= 1'b0;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign in_ready     = !r_skid_valid;
    end else begin : g_noskid
      always_ff @(posedge clk) begin
        if (reset) begin
          r_main_valid   <= 1'b0;
          r_main_ctrl    <= '0;
          r_main_alu     <= '0;
          r_main_wdata   <= '0;
          r_main_rd      <= '0;
          r_main_pcplus4 <= '0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_valid   <= 1'b1;
          r_main_ctrl    <= in_ctrl;
          r_main_alu     <= in_alu;
          r_main_wdata   <= in_wdata;
          r_main_rd      <= in_rd;
          r_main_pcplus4 <= in_pcplus4;
        end else if (w_pop) begin
          r_main_valid <= 1'b0;
        end
      end

      assign w_skid_valid = 1'b0;
      assign in_ready     = !r_main_valid || out_ready;
    end
  endgenerate

  // Bubbles carry zero control and rd; datapath fields keep their last value.
  assign out_valid   = r_main_valid;
  assign out_ctrl    = r_main_valid ? r_main_ctrl : '0;
  assign out_rd      = r_main_valid ? r_main_rd : '0;
  assign out_alu     = r_main_alu;
  assign out_wdata   = r_main_wdata;
  assign out_pcplus4 = r_main_pcplus4;
  assign occupancy   = 2'(r_main_valid) + 2'(w_skid_valid);

  a_in_hold : assert property (@(posedge clk) disable iff (reset)
    $past(in_valid && !in_ready && !flush && !reset) |->
      (in_valid && in_ctrl == $past(in_ctrl) && in_alu == $past(in_alu) &&
       in_wdata == $past(in_wdata) && in_rd == $past(in_rd) &&
       in_pcplus4 == $past(in_pcplus4)));

  a_no_x : assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_valid, in_ready, out_valid, out_ready}));

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: index 1 is the SKID=1 build, index 0 the SKID=0 build.
module tb_ex_mem_skid_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        iv[2], ir[2], ordy[2], fl[2], ov[2];
  logic [3:0]  ictrl[2], octrl[2];
  logic [31:0] ialu[2], iwd[2], ipc[2], oalu[2], owd[2], opc[2];
  logic [4:0]  ird[2], ord_[2];
  logic [1:0]  occ[2];

  int n_chk = 0;
  int n_err = 0;

  ex_mem_skid_stage #(.word_width(32), .CTRL_W(4), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_ctrl(ictrl[1]), .in_alu(ialu[1]), .in_wdata(iwd[1]), .in_rd(ird[1]),
    .in_pcplus4(ipc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(octrl[1]),
    .out_alu(oalu[1]), .out_wdata(owd[1]), .out_rd(ord_[1]), .out_pcplus4(opc[1]),
    .occupancy(occ[1]));

  ex_mem_skid_stage #(.word_width(32), .CTRL_W(4), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_ctrl(ictrl[0]), .in_alu(ialu[0]), .in_wdata(iwd[0]), .in_rd(ird[0]),
    .in_pcplus4(ipc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(octrl[0]),
    .out_alu(oalu[0]), .out_wdata(owd[0]), .out_rd(ord_[0]), .out_pcplus4(opc[0]),
    .occupancy(occ[0]));

  typedef struct {
    logic iv; logic [3:0] ctrl; logic [31:0] alu; logic [4:0] rd; logic ordy; logic fl;
    logic e_ov; logic [3:0] e_ctrl; logic [31:0] e_alu; logic [4:0] e_rd;
    logic [1:0] e_occ; logic e_ir;
  } vec_t;

  typedef struct packed {
    logic [3:0] ctrl; logic [31:0] alu; logic [31:0] wdata; logic [4:0] rd; logic [31:0] pc;
  } ent_t;

  vec_t tbl[23];
  ent_t mq[2][$];
  ent_t last_head[2];
  bit   held[2];

  function automatic vec_t mk(int v, int c, int a, int r, int o, int f,
                              int eov, int ec, int ea, int er, int eocc, int eir);
    vec_t t;
    t.iv = 1'(v); t.ctrl = 4'(c); t.alu = 32'(a); t.rd = 5'(r); t.ordy = 1'(o); t.fl = 1'(f);
    t.e_ov = 1'(eov); t.e_ctrl = 4'(ec); t.e_alu = 32'(ea); t.e_rd = 5'(er);
    t.e_occ = 2'(eocc); t.e_ir = 1'(eir);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input int k, input int v, input int c, input int a, input int r,
                       input int o, input int f);
    iv[k] = 1'(v); ictrl[k] = 4'(c); ialu[k] = 32'(a); iwd[k] = 32'(a) ^ 32'hA5A5_0000;
    ipc[k] = 32'(a) + 32'd4; ird[k] = 5'(r); ordy[k] = 1'(o); fl[k] = 1'(f);
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk($sformatf("%s k%0d out_valid", tag, k), 32'(ov[k]), 32'd0);
    chk($sformatf("%s k%0d out_ctrl", tag, k), 32'(octrl[k]), 32'd0);
    chk($sformatf("%s k%0d out_alu", tag, k), oalu[k], 32'd0);
    chk($sformatf("%s k%0d out_wdata", tag, k), owd[k], 32'd0);
    chk($sformatf("%s k%0d out_rd", tag, k), 32'(ord_[k]), 32'd0);
    chk($sformatf("%s k%0d out_pcplus4", tag, k), opc[k], 32'd0);
    chk($sformatf("%s k%0d occupancy", tag, k), 32'(occ[k]), 32'd0);
    chk($sformatf("%s k%0d in_ready", tag, k), 32'(ir[k]), 32'd1);
  endtask

  // Queue model: in_ready from fill level, head shown when non-empty, else last head.
  task automatic model_step(input int k);
    int   sz;
    bit   e_ir, e_ov, pop, acc;
    ent_t h;
    sz   = mq[k].size();
    e_ir = (k == 1) ? (sz < 2) : (sz == 0 || ordy[k]);
    e_ov = (sz > 0);
    h    = e_ov ? mq[k][0] : last_head[k];
    chk($sformatf("rnd k%0d out_valid", k), 32'(ov[k]), 32'(e_ov));
    chk($sformatf("rnd k%0d in_ready", k), 32'(ir[k]), 32'(e_ir));
    chk($sformatf("rnd k%0d out_ctrl", k), 32'(octrl[k]), e_ov ? 32'(h.ctrl) : 32'd0);
    chk($sformatf("rnd k%0d out_rd", k), 32'(ord_[k]), e_ov ? 32'(h.rd) : 32'd0);
    chk($sformatf("rnd k%0d out_alu", k), oalu[k], h.alu);
    chk($sformatf("rnd k%0d out_wdata", k), owd[k], h.wdata);
    chk($sformatf("rnd k%0d out_pcplus4", k), opc[k], h.pc);
    chk($sformatf("rnd k%0d occupancy", k), 32'(occ[k]), 32'(sz));
    last_head[k] = h;
    pop = e_ov && ordy[k];
    acc = iv[k] && e_ir;
    if (pop) void'(mq[k].pop_front());
    if (acc && !fl[k]) mq[k].push_back({ictrl[k], ialu[k], iwd[k], ird[k], ipc[k]});
    if (fl[k]) mq[k].delete();
    held[k] = iv[k] && !e_ir && !fl[k];
  endtask

  localparam int CC = 4'b1010;

  initial begin
    tbl[0]  = mk(1, CC, 'h10, 1, 1, 0,  0, 0,  'h0,  0, 0, 1);
    tbl[1]  = mk(1, CC, 'h20, 2, 1, 0,  1, CC, 'h10, 1, 1, 1);
    tbl[2]  = mk(1, CC, 'h30, 3, 1, 0,  1, CC, 'h20, 2, 1, 1);
    tbl[3]  = mk(1, CC, 'h40, 4, 1, 0,  1, CC, 'h30, 3, 1, 1);
    tbl[4]  = mk(0, 0,  0,    0, 1, 0,  1, CC, 'h40, 4, 1, 1);
    tbl[5]  = mk(0, 0,  0,    0, 1, 0,  0, 0,  'h40, 0, 0, 1);
    tbl[6]  = mk(1, CC, 'hA,  5, 0, 0,  0, 0,  'h40, 0, 0, 1);
    tbl[7]  = mk(1, CC, 'hB,  6, 0, 0,  1, CC, 'hA,  5, 1, 1);
    tbl[8]  = mk(1, CC, 'hC,  7, 0, 0,  1, CC, 'hA,  5, 2, 0);
    tbl[9]  = mk(1, CC, 'hC,  7, 1, 0,  1, CC, 'hA,  5, 2, 0);
    tbl[10] = mk(1, CC, 'hC,  7, 1, 0,  1, CC, 'hB,  6, 1, 1);
    tbl[11] = mk(0, 0,  0,    0, 1, 0,  1, CC, 'hC,  7, 1, 1);
    tbl[12] = mk(0, 0,  0,    0, 1, 0,  0, 0,  'hC,  0, 0, 1);
    tbl[13] = mk(1, CC, 'hD1, 8, 0, 0,  0, 0,  'hC,  0, 0, 1);
    tbl[14] = mk(1, CC, 'hD2, 9, 0, 0,  1, CC, 'hD1, 8, 1, 1);
    tbl[15] = mk(1, 'b0110, 'hC, 10, 0, 1, 1, CC, 'hD1, 8, 2, 0);
    tbl[16] = mk(0, 0,  0,    0, 0, 0,  0, 0,  'hD1, 0, 0, 1);
    tbl[17] = mk(0, 0,  0,    0, 1, 0,  0, 0,  'hD1, 0, 0, 1);
    tbl[18] = mk(1, 'b1001, 'h99, 7, 1, 0, 0, 0, 'hD1, 0, 0, 1);
    tbl[19] = mk(0, 0,  0,    0, 1, 0,  1, 'b1001, 'h99, 7, 1, 1);
    tbl[20] = mk(0, 0,  0,    0, 1, 0,  0, 0,  'h99, 0, 0, 1);
    tbl[21] = mk(0, 0,  0,    0, 1, 0,  0, 0,  'h99, 0, 0, 1);
    tbl[22] = mk(0, 0,  0,    0, 1, 0,  0, 0,  'h99, 0, 0, 1);

    for (int k = 0; k < 2; k++) drive(k, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk_zero(1, "reset");
    chk_zero(0, "reset");

    // stream, back-pressure, flush-while-full and bubble sequences on the skid build
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(1, int'(tbl[i].iv), int'(tbl[i].ctrl), int'(tbl[i].alu), int'(tbl[i].rd),
            int'(tbl[i].ordy), int'(tbl[i].fl));
      #1;
      chk($sformatf("tbl%0d out_valid", i), 32'(ov[1]), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d out_ctrl", i), 32'(octrl[1]), 32'(tbl[i].e_ctrl));
      chk($sformatf("tbl%0d out_alu", i), oalu[1], tbl[i].e_alu);
      chk($sformatf("tbl%0d out_rd", i), 32'(ord_[1]), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d occupancy", i), 32'(occ[1]), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d in_ready", i), 32'(ir[1]), 32'(tbl[i].e_ir));
    end

    // reset while full
    @(negedge clk) drive(1, 1, CC, 'hE1, 11, 0, 0);
    @(negedge clk) drive(1, 1, CC, 'hE2, 12, 0, 0);
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midreset occupancy before", 32'(occ[1]), 32'd2);
    chk("midreset in_ready before", 32'(ir[1]), 32'd0);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    #1;
    chk_zero(1, "midreset");
    @(negedge clk) drive(1, 1, CC, 'h55, 13, 0, 0);
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midreset new out_valid", 32'(ov[1]), 32'd1);
    chk("midreset new out_alu", oalu[1], 32'h55);
    chk("midreset new out_rd", 32'(ord_[1]), 32'd13);

    // single-entry build: combinational in_ready and same-cycle replacement
    @(negedge clk) drive(0, 1, CC, 'h66, 3, 0, 0);
    #1;
    chk("noskid in_ready empty", 32'(ir[0]), 32'd1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("noskid in_ready ordy1", 32'(ir[0]), 32'd1);
    chk("noskid out_alu held", oalu[0], 32'h66);
    ordy[0] = 1'b0;
    #1;
    chk("noskid in_ready ordy0", 32'(ir[0]), 32'd0);
    chk("noskid occupancy full", 32'(occ[0]), 32'd1);
    @(negedge clk) drive(0, 1, CC, 'h77, 5, 1, 0);
    #1;
    chk("noskid in_ready replace", 32'(ir[0]), 32'd1);
    chk("noskid out_alu before", oalu[0], 32'h66);
    @(negedge clk) drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("noskid out_alu after", oalu[0], 32'h77);
    chk("noskid out_rd after", 32'(ord_[0]), 32'd5);
    chk("noskid occupancy after", 32'(occ[0]), 32'd1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("noskid bubble valid", 32'(ov[0]), 32'd0);
    chk("noskid bubble ctrl", 32'(octrl[0]), 32'd0);
    chk("noskid bubble alu", oalu[0], 32'h77);

    // randomized traffic on both builds against the queue model
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 2; k++) drive(k, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      last_head[k] = '0;
      held[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!held[k]) begin
          iv[k]    = ($urandom_range(0, 9) < 7);
          ictrl[k] = 4'($urandom);
          ialu[k]  = $urandom;
          iwd[k]   = $urandom;
          ird[k]   = 5'($urandom);
          ipc[k]   = $urandom;
        end
        ordy[k] = ($urandom_range(0, 9) < 6);
        fl[k]   = ($urandom_range(0, 19) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) model_step(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
